// File: rtl/fft_frame_loader.sv
// Serial-to-parallel frame loader that feeds the 16-point FFT: a fill buffer plus an output holding register.
// Optional start-of-frame realignment via `define FFT_FRAME_LOADER_SOF_EN (adds s_sof, drives frame_err).
module fft_frame_loader #(
  parameter int unsigned N_POINTS = 16,
  parameter int unsigned DATA_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_W-1:0]            s_real,
  input  logic [DATA_W-1:0]            s_im,
`ifdef FFT_FRAME_LOADER_SOF_EN
  input  logic                         s_sof,
`endif
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [N_POINTS*DATA_W-1:0]   m_frame_real,
  output logic [N_POINTS*DATA_W-1:0]   m_frame_im,
  output logic                         frame_err
);

  localparam int unsigned CNT_W   = $clog2(N_POINTS);
  localparam int unsigned FRAME_W = N_POINTS * DATA_W;
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N_POINTS - 1);

  typedef enum logic {StFill, StFull} state_e;

  state_e             state;
  logic [CNT_W-1:0]   wr_cnt;
  logic [FRAME_W-1:0] fill_real;
  logic [FRAME_W-1:0] fill_im;
  logic               accept;
  logic               out_free;
  logic               sof_restart;

  assign s_ready  = !rst && (state == StFill);
  assign accept   = s_valid && s_ready;
  assign out_free = !m_valid || m_ready;

`ifdef FFT_FRAME_LOADER_SOF_EN
  logic frame_err_q;
  assign sof_restart = s_sof && (wr_cnt != '0);
  assign frame_err   = frame_err_q;
`else
  assign sof_restart = 1'b0;
  assign frame_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StFill;
      wr_cnt       <= '0;
      m_valid      <= 1'b0;
      m_frame_real <= '0;
      m_frame_im   <= '0;
      fill_real    <= '0;
      fill_im      <= '0;
`ifdef FFT_FRAME_LOADER_SOF_EN
      frame_err_q  <= 1'b0;
`endif
    end else begin
      // Consumption clears m_valid; a load on the same edge below overrides it.
      if (m_valid && m_ready) m_valid <= 1'b0;
      unique case (state)
        StFill: begin
          if (accept) begin
            if (sof_restart) begin
              // Realign: drop the partial frame and restart at slot 0.
              fill_real[DATA_W-1:0] <= s_real;
              fill_im[DATA_W-1:0]   <= s_im;
              wr_cnt                <= CNT_W'(1);
`ifdef FFT_FRAME_LOADER_SOF_EN
              frame_err_q           <= 1'b1;
`endif
            end else begin
              fill_real[wr_cnt*DATA_W +: DATA_W] <= s_real;
              fill_im[wr_cnt*DATA_W +: DATA_W]   <= s_im;
              if (wr_cnt == LastIdx) begin
                wr_cnt <= '0;
                if (out_free) begin
                  // Bypass the last sample straight into the output register.
                  m_frame_real <= {s_real, fill_real[FRAME_W-DATA_W-1:0]};
                  m_frame_im   <= {s_im, fill_im[FRAME_W-DATA_W-1:0]};
                  m_valid      <= 1'b1;
                end else begin
                  state <= StFull;
                end
              end else begin
                wr_cnt <= wr_cnt + CNT_W'(1);
              end
            end
          end
        end
        StFull: begin
          if (out_free) begin
            m_frame_real <= fill_real;
            m_frame_im   <= fill_im;
            m_valid      <= 1'b1;
            state        <= StFill;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Input stage that sits directly upstream of the 16-point radix-2 FFT pipeline.
- Accepts a serial stream of complex 16-bit samples over a valid/ready handshake and collects them into 16-sample frames.
- Presents each complete frame in parallel, in natural order (sample 0..15), with a valid/ready handshake; bit-reversed ordering is handled downstream.
- Ping-pong arrangement: a fill buffer plus an output holding register, so intake continues while a completed frame waits to be consumed.

Parameters:
- N_POINTS, 16, samples per frame; fixed at 16 to match the FFT, and the counter width is log2(N_POINTS).
- DATA_W, 16, width of each real and imaginary component (two's complement).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  loader can accept a sample this cycle.
- s_real  in  DATA_W  input sample, real part.
- s_im  in  DATA_W  input sample, imaginary part.
- m_valid  out  1  output frame valid.
- m_ready  in  1  downstream consumes the frame this cycle.
- m_frame_real  out  N_POINTS*DATA_W  sample k at bits [k*DATA_W +: DATA_W].
- m_frame_im  out  N_POINTS*DATA_W  same packing as m_frame_real.
- frame_err  out  1  sticky realignment flag; only with the optional feature, otherwise tied 0.

Behaviour:
- Reset (asynchronous, immediate):
  - wr_cnt=0, state=FILL, m_valid=0, m_frame_real/m_frame_im=0, fill buffer=0, frame_err=0.
  - s_ready is combinational and reads 1 while rst is low and state=FILL.
  - Reset mid-frame discards any partial frame and any held output frame.
- Accept: a sample is taken at a rising edge when s_valid && s_ready. It is written to fill[wr_cnt], then wr_cnt increments.
- Slot free: out_free = !m_valid || m_ready.
- State FILL (s_ready=1):
  - Accepting a sample with wr_cnt<15: store it, wr_cnt+1.
  - Accepting a sample with wr_cnt==15 and out_free:
    - samples 0..14 plus the incoming sample 15 go into the output registers on that edge;
    - m_valid=1, wr_cnt=0, stay in FILL.
  - Accepting a sample with wr_cnt==15 and !out_free: store the sample, wr_cnt=0, go to FULL.
- State FULL (s_ready=0):
  - When out_free: copy the fill buffer to the output registers, m_valid=1, go to FILL.
  - Otherwise hold.
- Output handshake:
  - m_valid && m_ready at an edge consumes the frame.
  - m_valid drops at that edge unless a new frame is loaded on the same edge, in which case m_valid stays 1 and the data updates (back-to-back frames, no bubble).
  - While m_valid && !m_ready, m_frame_* are stable.
- Latency:
  - m_valid rises the cycle after the edge that accepted sample 15, when the slot is free.
  - Sustained throughput is 1 sample/clk with m_ready tied high.
- Data is stored unmodified; there is no arithmetic or scaling.
- s_valid=0 in any state changes nothing; wr_cnt holds partial progress indefinitely.
- wr_cnt wraps 15 -> 0 only on a frame boundary.

Optional Feature:
- Macro: FFT_FRAME_LOADER_SOF_EN.
- With the macro defined, an extra input port s_sof (1 bit) marks sample 0 of a frame.
  - Accepted sample with s_sof=1 and wr_cnt!=0: the partial frame is discarded, the sample is written to fill[0], wr_cnt=1, and frame_err is set. frame_err is sticky until rst.
  - s_sof=1 with wr_cnt==0: normal accept.
  - s_sof is ignored in FULL, because no accept occurs there.
- Without the macro: no s_sof port, frame_err is constant 0, and framing relies purely on sample count from reset.

Test Plan:
- Stream samples k=0..15 (real=k, im=-k) with m_ready=1 -> m_valid high for exactly 1 cycle, one cycle after sample 15; m_frame_real slot 5=0x0005, m_frame_im slot 5=0xFFFB.
- Two frames back-to-back with s_valid=1 and m_ready=1 for 32 cycles -> s_ready never drops; m_valid pulses on cycle 17 and cycle 33; the second frame holds values 16..31.
- m_ready=0, send 32 samples -> first frame held stable; s_ready drops after sample 31 (state FULL). Raise m_ready for 1 cycle -> second frame loads, m_valid stays 1, s_ready returns to 1.
- Assert rst asynchronously (mid-clock) after 7 samples of a frame -> outputs and wr_cnt clear immediately. Next 16 samples (100..115) form a frame with slot 0=100.
- Random s_valid gaps (~50% duty) over 10 frames -> every frame matches the reference ordering; no sample is lost or duplicated.
- With FFT_FRAME_LOADER_SOF_EN: send 5 samples, then a sample with s_sof=1 followed by 15 more -> emitted frame starts with the s_sof sample; frame_err=1 and stays 1 until rst.
